// File: rtl/demux_116_seq_pkg.sv
// Shared types and widths for the 1:16 serial-to-parallel demux.
package demux_116_seq_pkg;

  localparam int FRAME_W = 16;
  localparam int IDX_W   = 4;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_W - 1);

endpackage

// File: rtl/demux_116_seq_dec.sv
// 4-to-16 one-hot write-enable decoder for the shadow register bits.
module demux_116_dec
  import demux_116_seq_pkg::*;
(
  input  logic               i_en,
  input  logic [IDX_W-1:0]   i_idx,
  output logic [FRAME_W-1:0] o_we
);

  always_comb begin
    o_we = '0;
    if (i_en) o_we[i_idx] = 1'b1;
  end

endmodule

// File: rtl/demux_116_seq.sv
// Serial-to-parallel frame collector: 16 qualified bits, sof-aligned, into a
// held output frame with acknowledge handshake and sticky overrun flag.
module demux_116_seq
  import demux_116_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               din,
  input  logic               din_valid,
  input  logic               sof,
  input  logic               frame_ack,
  output logic [IDX_W-1:0]   s,
  output logic [FRAME_W-1:0] dout,
  output logic               frame_valid,
  output logic               busy,
  output logic               overrun
);

  // state      | meaning
  // ST_IDLE    | waiting for a valid bit with sof
  // ST_COLLECT | bits 1..15 of a frame being captured

  state_t               r_state;
  state_t               w_next_state;
  logic [IDX_W-1:0]     r_s;
  logic [FRAME_W-1:0]   r_shadow;
  logic [FRAME_W-1:0]   r_dout;
  logic                 r_frame_valid;
  logic                 r_overrun;

  logic                 w_take;
  logic                 w_complete;
  logic                 w_load;
  logic                 w_drop;
  logic [IDX_W-1:0]     w_idx;
  logic [IDX_W-1:0]     w_s_next;
  logic [FRAME_W-1:0]   w_we;
  logic [FRAME_W-1:0]   w_frame;

  assign w_take     = din_valid && (sof || (r_state == ST_COLLECT));
  assign w_idx      = sof ? '0 : r_s;
  assign w_complete = din_valid && !sof && (r_state == ST_COLLECT) && (r_s == IDX_LAST);

  demux_116_dec u_dec (
    .i_en  (w_take),
    .i_idx (w_idx),
    .o_we  (w_we)
  );

  // The frame with the current bit merged in; on completion this is {din, shadow[14:0]}.
  always_comb begin
    for (int k = 0; k < FRAME_W; k++)
      w_frame[k] = w_we[k] ? din : r_shadow[k];
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (din_valid && sof) w_next_state = ST_COLLECT;
      ST_COLLECT: if (w_complete)       w_next_state = ST_IDLE;
      default:                          w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_s_next = r_s;
    if (w_take) w_s_next = sof ? IDX_W'(1) : r_s + IDX_W'(1);
    w_load = w_complete && (!r_frame_valid || frame_ack);
    w_drop = w_complete && r_frame_valid && !frame_ack;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s           <= '0;
      r_shadow      <= '0;
      r_dout        <= '0;
      r_frame_valid <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_s      <= w_s_next;
      r_shadow <= w_frame;
      if (w_load) begin
        r_dout        <= w_frame;
        r_frame_valid <= 1'b1;
      end else if (frame_ack) begin
        r_frame_valid <= 1'b0;
      end
      if (w_drop) r_overrun <= 1'b1;
    end
  end

  assign s           = r_s;
  assign dout        = r_dout;
  assign frame_valid = r_frame_valid;
  assign busy        = (r_state == ST_COLLECT);
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_demux_116_seq.sv
// Directed self-checking bench for demux_116_seq.
module tb_demux_116_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din = 1'b0;
  logic        din_valid = 1'b0;
  logic        sof = 1'b0;
  logic        frame_ack = 1'b0;
  logic [3:0]  s;
  logic [15:0] dout;
  logic        frame_valid;
  logic        busy;
  logic        overrun;

  int n_checks = 0;
  int n_fail = 0;

  demux_116_seq dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sof(sof),
    .frame_ack(frame_ack), .s(s), .dout(dout), .frame_valid(frame_valid),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // One clock with a qualified bit; outputs are observed 1ns after the edge.
  task automatic drive_bit(input logic b, input logic f, input logic ack);
    din = b; din_valid = 1'b1; sof = f; frame_ack = ack;
    @(posedge clk); #1;
    din = 1'b0; din_valid = 1'b0; sof = 1'b0; frame_ack = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic send_bits(input logic [15:0] d, input int lo, input int hi, input logic ack_last);
    for (int k = lo; k <= hi; k++)
      drive_bit(d[k], k == 0, (k == hi) ? ack_last : 1'b0);
  endtask

  task automatic do_ack();
    frame_ack = 1'b1;
    @(posedge clk); #1;
    frame_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_cycles(2);
    rst = 1'b0;
    n_checks++; if (s !== 4'd0) begin n_fail++; $display("FAIL reset_s got=%0d exp=0", s); end
    n_checks++; if (dout !== 16'h0000) begin n_fail++; $display("FAIL reset_dout got=%h exp=0000", dout); end
    n_checks++; if ({frame_valid, busy, overrun} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {frame_valid, busy, overrun}); end
    drive_bit(1'b1, 1'b0, 1'b0);
    n_checks++; if ({busy, s} !== 5'd0) begin n_fail++; $display("FAIL idle_nonsof_ignored busy,s got=%h exp=00", {busy, s}); end
  endtask

  task automatic test_basic();
    send_bits(16'hAAAA, 0, 0, 1'b0);
    n_checks++; if ({busy, s} !== {1'b1, 4'd1}) begin n_fail++; $display("FAIL basic_first_bit busy,s got=%h exp=11", {busy, s}); end
    send_bits(16'hAAAA, 1, 14, 1'b0);
    n_checks++; if ({frame_valid, s} !== {1'b0, 4'd15}) begin n_fail++; $display("FAIL basic_before_last fv,s got=%h exp=0f", {frame_valid, s}); end
    send_bits(16'hAAAA, 15, 15, 1'b0);
    n_checks++; if (dout !== 16'hAAAA) begin n_fail++; $display("FAIL basic_dout got=%h exp=aaaa", dout); end
    n_checks++; if ({frame_valid, busy, s} !== {1'b1, 1'b0, 4'd0}) begin n_fail++; $display("FAIL basic_flags fv,busy,s got=%h exp=20", {frame_valid, busy, s}); end
    do_ack();
    n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL basic_ack_clears got=%b exp=0", frame_valid); end
    do_ack();
    n_checks++; if ({frame_valid, dout} !== {1'b0, 16'hAAAA}) begin n_fail++; $display("FAIL ack_when_empty fv,dout got=%h exp=0aaaa", {frame_valid, dout}); end
  endtask

  task automatic test_gap();
    send_bits(16'h1234, 0, 7, 1'b0);
    for (int g = 0; g < 3; g++) begin
      idle_cycles(1);
      n_checks++; if ({busy, s} !== {1'b1, 4'd8}) begin n_fail++; $display("FAIL gap_hold cyc=%0d busy,s got=%h exp=18", g, {busy, s}); end
    end
    send_bits(16'h1234, 8, 15, 1'b0);
    n_checks++; if ({frame_valid, dout} !== {1'b1, 16'h1234}) begin n_fail++; $display("FAIL gap_dout fv,dout got=%h exp=11234", {frame_valid, dout}); end
    do_ack();
  endtask

  task automatic test_abort();
    send_bits(16'hFFFF, 0, 4, 1'b0);
    n_checks++; if (s !== 4'd5) begin n_fail++; $display("FAIL abort_partial_s got=%0d exp=5", s); end
    send_bits(16'h00F0, 0, 0, 1'b0);
    n_checks++; if ({busy, s} !== {1'b1, 4'd1}) begin n_fail++; $display("FAIL abort_restart busy,s got=%h exp=11", {busy, s}); end
    send_bits(16'h00F0, 1, 15, 1'b0);
    n_checks++; if (dout !== 16'h00F0) begin n_fail++; $display("FAIL abort_dout got=%h exp=00f0", dout); end
    n_checks++; if ({frame_valid, overrun} !== 2'b10) begin n_fail++; $display("FAIL abort_flags fv,ovr got=%b exp=10", {frame_valid, overrun}); end
    do_ack();
  endtask

  task automatic test_overrun();
    send_bits(16'hAAAA, 0, 15, 1'b0);
    n_checks++; if ({frame_valid, overrun, dout} !== {2'b10, 16'hAAAA}) begin n_fail++; $display("FAIL ovr_first got=%h exp=2aaaa", {frame_valid, overrun, dout}); end
    send_bits(16'h5555, 0, 15, 1'b0);
    n_checks++; if (dout !== 16'hAAAA) begin n_fail++; $display("FAIL ovr_dout_kept got=%h exp=aaaa", dout); end
    n_checks++; if ({frame_valid, overrun} !== 2'b11) begin n_fail++; $display("FAIL ovr_flag fv,ovr got=%b exp=11", {frame_valid, overrun}); end
    send_bits(16'h0F0F, 0, 15, 1'b1);
    n_checks++; if (dout !== 16'h0F0F) begin n_fail++; $display("FAIL ovr_ack_complete_dout got=%h exp=0f0f", dout); end
    n_checks++; if ({frame_valid, overrun} !== 2'b11) begin n_fail++; $display("FAIL ovr_ack_complete_flags fv,ovr got=%b exp=11", {frame_valid, overrun}); end
    do_ack();
    n_checks++; if ({frame_valid, overrun} !== 2'b01) begin n_fail++; $display("FAIL ovr_sticky fv,ovr got=%b exp=01", {frame_valid, overrun}); end
  endtask

  task automatic test_rst_mid();
    send_bits(16'hFFFF, 0, 8, 1'b0);
    n_checks++; if (s !== 4'd9) begin n_fail++; $display("FAIL rstmid_pre_s got=%0d exp=9", s); end
    rst = 1'b1;
    drive_bit(1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    n_checks++; if ({busy, s} !== 5'd0) begin n_fail++; $display("FAIL rstmid_busy_s got=%h exp=00", {busy, s}); end
    n_checks++; if ({frame_valid, overrun, dout} !== 18'd0) begin n_fail++; $display("FAIL rstmid_out got=%h exp=00000", {frame_valid, overrun, dout}); end
    for (int k = 0; k < 3; k++) drive_bit(1'b1, 1'b0, 1'b0);
    n_checks++; if ({busy, s} !== 5'd0) begin n_fail++; $display("FAIL rstmid_nonsof_ignored got=%h exp=00", {busy, s}); end
    send_bits(16'h5A5A, 0, 15, 1'b0);
    n_checks++; if ({frame_valid, dout} !== {1'b1, 16'h5A5A}) begin n_fail++; $display("FAIL rstmid_next_frame got=%h exp=15a5a", {frame_valid, dout}); end
    do_ack();
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    logic [3:0]  sel;
    d = 16'hC3A5;
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 0; k < 16; k++) begin
        sel = 4'(k);
        drive_bit(d[sel], sel == 4'd0, sel == 4'd15);
        if (rep == 1 && k == 0) begin
          n_checks++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_held_between got=%b exp=1", frame_valid); end
        end
      end
      n_checks++; if ({frame_valid, dout} !== {1'b1, 16'hC3A5}) begin n_fail++; $display("FAIL b2b_frame%0d got=%h exp=1c3a5", rep, {frame_valid, dout}); end
    end
    n_checks++; if ({overrun, busy, s} !== 6'd0) begin n_fail++; $display("FAIL b2b_end_state got=%h exp=00", {overrun, busy, s}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_abort();
    test_overrun();
    test_rst_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
